// File: rtl/vx_tl_source_tracker.sv
// Bridges the core line-granular memory port to TileLink-UH A/D channels with per-request source tracking.
// Optional perf counters (perf_reads, perf_writes, perf_stall_cycles) are built when VX_TL_PERF_EN is defined.
module vx_tl_source_tracker #(
    parameter int unsigned NUM_SOURCES = 8,
    parameter int unsigned CORE_TAG_W  = 15,
    parameter int unsigned LINE_ADDR_W = 28,
    parameter int unsigned DATA_W      = 128,
    parameter int unsigned TL_SOURCE_W = 15
) (
    input  logic                   clock,
    input  logic                   reset_n,

    input  logic                   core_req_valid,
    input  logic                   core_req_rw,
    input  logic [DATA_W/8-1:0]    core_req_byteen,
    input  logic [LINE_ADDR_W-1:0] core_req_addr,
    input  logic [DATA_W-1:0]      core_req_data,
    input  logic [CORE_TAG_W-1:0]  core_req_tag,
    output logic                   core_req_ready,

    output logic                   core_rsp_valid,
    output logic [DATA_W-1:0]      core_rsp_data,
    output logic [CORE_TAG_W-1:0]  core_rsp_tag,
    input  logic                   core_rsp_ready,

    output logic                   tl_a_valid,
    input  logic                   tl_a_ready,
    output logic [2:0]             tl_a_opcode,
    output logic [2:0]             tl_a_param,
    output logic [3:0]             tl_a_size,
    output logic [TL_SOURCE_W-1:0] tl_a_source,
    output logic [31:0]            tl_a_address,
    output logic [DATA_W/8-1:0]    tl_a_mask,
    output logic [DATA_W-1:0]      tl_a_data,
    output logic                   tl_a_corrupt,

    input  logic                   tl_d_valid,
    output logic                   tl_d_ready,
    input  logic [2:0]             tl_d_opcode,
    input  logic [TL_SOURCE_W-1:0] tl_d_source,
    input  logic [DATA_W-1:0]      tl_d_data,
    input  logic                   tl_d_denied,

`ifdef VX_TL_PERF_EN
    output logic [31:0]            perf_reads,
    output logic [31:0]            perf_writes,
    output logic [31:0]            perf_stall_cycles,
`endif
    output logic                   busy,
    output logic                   err
);

    localparam int unsigned SRC_IDX_W = $clog2(NUM_SOURCES);
    localparam int unsigned MASK_W    = DATA_W / 8;
    localparam int unsigned CNT_W     = SRC_IDX_W + 1;

    localparam logic [2:0] OP_PUT_FULL    = 3'd0;
    localparam logic [2:0] OP_PUT_PARTIAL = 3'd1;
    localparam logic [2:0] OP_GET         = 3'd4;
    localparam logic [2:0] OP_ACK         = 3'd0;
    localparam logic [2:0] OP_ACK_DATA    = 3'd1;

    // Two-entry request FIFO
    logic                   r_fifo_rw     [2];
    logic [MASK_W-1:0]      r_fifo_byteen [2];
    logic [LINE_ADDR_W-1:0] r_fifo_addr   [2];
    logic [DATA_W-1:0]      r_fifo_data   [2];
    logic [CORE_TAG_W-1:0]  r_fifo_tag    [2];
    logic                   r_wr_ptr;
    logic                   r_rd_ptr;
    logic [1:0]             r_fifo_cnt;

    // Source table
    logic [NUM_SOURCES-1:0] r_src_busy;
    logic [NUM_SOURCES-1:0] r_src_rw;
    logic [CORE_TAG_W-1:0]  r_src_tag [NUM_SOURCES];
    logic [CNT_W-1:0]       r_out_cnt;
    logic                   r_a_hold;
    logic [SRC_IDX_W-1:0]   r_a_hold_idx;
    logic                   r_err;

    logic                   w_fifo_full;
    logic                   w_fifo_empty;
    logic                   w_push;
    logic                   w_a_fire;
    logic                   w_any_free;
    logic [SRC_IDX_W-1:0]   w_free_idx;
    logic [SRC_IDX_W-1:0]   w_alloc_idx;
    logic                   w_head_rw;
    logic [MASK_W-1:0]      w_head_byteen;

    logic [SRC_IDX_W-1:0]   w_d_idx;
    logic                   w_d_in_range;
    logic                   w_d_busy;
    logic                   w_d_rw;
    logic                   w_d_bad;
    logic                   w_d_fire;
    logic                   w_d_free;

    assign w_fifo_full   = (r_fifo_cnt == 2'd2);
    assign w_fifo_empty  = (r_fifo_cnt == 2'd0);
    assign w_push        = core_req_valid & ~w_fifo_full;
    assign w_head_rw     = r_fifo_rw[r_rd_ptr];
    assign w_head_byteen = r_fifo_byteen[r_rd_ptr];

    // Lowest free source from the registered busy vector only
    always_comb begin
        w_free_idx = '0;
        w_any_free = ~(&r_src_busy);
        for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
            if (!r_src_busy[i]) begin
                w_free_idx = SRC_IDX_W'(i);
            end
        end
    end

    // A held source stays free until it fires, so the hold never points at a busy slot
    assign w_alloc_idx = r_a_hold ? r_a_hold_idx : w_free_idx;
    assign w_a_fire    = tl_a_valid & tl_a_ready;

    assign core_req_ready = ~w_fifo_full;
    assign tl_a_valid     = ~w_fifo_empty & w_any_free;
    assign tl_a_opcode    = w_head_rw ? ((&w_head_byteen) ? OP_PUT_FULL : OP_PUT_PARTIAL) : OP_GET;
    assign tl_a_param     = 3'd0;
    assign tl_a_size      = 4'd4;
    assign tl_a_source    = TL_SOURCE_W'(w_alloc_idx);
    assign tl_a_address   = 32'({r_fifo_addr[r_rd_ptr], 4'b0000});
    assign tl_a_mask      = w_head_rw ? w_head_byteen : {MASK_W{1'b1}};
    assign tl_a_data      = r_fifo_data[r_rd_ptr];
    assign tl_a_corrupt   = 1'b0;

    assign w_d_idx      = tl_d_source[SRC_IDX_W-1:0];
    assign w_d_in_range = ((tl_d_source >> SRC_IDX_W) == '0);
    assign w_d_busy     = w_d_in_range & r_src_busy[w_d_idx];
    assign w_d_rw       = r_src_rw[w_d_idx];
    assign w_d_bad      = ~w_d_busy | (tl_d_opcode > OP_ACK_DATA) | tl_d_denied
                        | ((tl_d_opcode == OP_ACK) & ~w_d_rw)
                        | ((tl_d_opcode == OP_ACK_DATA) & w_d_rw);

    // Write acks are always sunk; data responses wait on the core
    assign tl_d_ready     = (tl_d_opcode == OP_ACK) ? 1'b1 : core_rsp_ready;
    assign w_d_fire       = tl_d_valid & tl_d_ready;
    assign w_d_free       = w_d_fire & w_d_busy;
    assign core_rsp_valid = tl_d_valid & (tl_d_opcode == OP_ACK_DATA) & ~w_d_bad;
    assign core_rsp_data  = tl_d_data;
    assign core_rsp_tag   = r_src_tag[w_d_idx];

    assign busy = ~w_fifo_empty | (r_out_cnt != '0);
    assign err  = r_err;

    // Control state
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_wr_ptr     <= 1'b0;
            r_rd_ptr     <= 1'b0;
            r_fifo_cnt   <= 2'd0;
            r_src_busy   <= '0;
            r_out_cnt    <= '0;
            r_a_hold     <= 1'b0;
            r_a_hold_idx <= '0;
            r_err        <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_a_fire) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_a_fire})
                2'b10:   r_fifo_cnt <= r_fifo_cnt + 2'd1;
                2'b01:   r_fifo_cnt <= r_fifo_cnt - 2'd1;
                default: r_fifo_cnt <= r_fifo_cnt;
            endcase

            if (w_a_fire) begin
                r_src_busy[w_alloc_idx] <= 1'b1;
            end
            if (w_d_free) begin
                r_src_busy[w_d_idx] <= 1'b0;
            end
            case ({w_a_fire, w_d_free})
                2'b10:   r_out_cnt <= r_out_cnt + CNT_W'(1);
                2'b01:   r_out_cnt <= r_out_cnt - CNT_W'(1);
                default: r_out_cnt <= r_out_cnt;
            endcase

            if (tl_a_valid && !tl_a_ready) begin
                r_a_hold     <= 1'b1;
                r_a_hold_idx <= w_alloc_idx;
            end else if (w_a_fire) begin
                r_a_hold     <= 1'b0;
            end

            if (w_d_fire && w_d_bad) begin
                r_err <= 1'b1;
            end
        end
    end

    // Payload storage, qualified by the control state above
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_fifo_rw[r_wr_ptr]     <= core_req_rw;
            r_fifo_byteen[r_wr_ptr] <= core_req_byteen;
            r_fifo_addr[r_wr_ptr]   <= core_req_addr;
            r_fifo_data[r_wr_ptr]   <= core_req_data;
            r_fifo_tag[r_wr_ptr]    <= core_req_tag;
        end
        if (w_a_fire) begin
            r_src_rw[w_alloc_idx]  <= w_head_rw;
            r_src_tag[w_alloc_idx] <= r_fifo_tag[r_rd_ptr];
        end
    end

`ifdef VX_TL_PERF_EN
    logic [31:0] r_perf_reads;
    logic [31:0] r_perf_writes;
    logic [31:0] r_perf_stall;

    // Saturating event counters
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_perf_reads  <= '0;
            r_perf_writes <= '0;
            r_perf_stall  <= '0;
        end else begin
            if (w_a_fire && !w_head_rw && (r_perf_reads != 32'hFFFF_FFFF)) begin
                r_perf_reads <= r_perf_reads + 32'd1;
            end
            if (w_a_fire && w_head_rw && (r_perf_writes != 32'hFFFF_FFFF)) begin
                r_perf_writes <= r_perf_writes + 32'd1;
            end
            if (!w_fifo_empty && (!tl_a_valid || !tl_a_ready) && (r_perf_stall != 32'hFFFF_FFFF)) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
        end
    end

    assign perf_reads        = r_perf_reads;
    assign perf_writes       = r_perf_writes;
    assign perf_stall_cycles = r_perf_stall;
`endif

endmodule

// File: tb/tb_vx_tl_source_tracker.sv
// Scoreboard bench for vx_tl_source_tracker: request queue checked at A fires, source model checked at D beats.
module tb_vx_tl_source_tracker;

    logic         clock = 1'b0;
    logic         reset_n;
    logic         core_req_valid;
    logic         core_req_rw;
    logic [15:0]  core_req_byteen;
    logic [27:0]  core_req_addr;
    logic [127:0] core_req_data;
    logic [14:0]  core_req_tag;
    logic         core_req_ready;
    logic         core_rsp_valid;
    logic [127:0] core_rsp_data;
    logic [14:0]  core_rsp_tag;
    logic         core_rsp_ready;
    logic         tl_a_valid;
    logic         tl_a_ready;
    logic [2:0]   tl_a_opcode;
    logic [2:0]   tl_a_param;
    logic [3:0]   tl_a_size;
    logic [14:0]  tl_a_source;
    logic [31:0]  tl_a_address;
    logic [15:0]  tl_a_mask;
    logic [127:0] tl_a_data;
    logic         tl_a_corrupt;
    logic         tl_d_valid;
    logic         tl_d_ready;
    logic [2:0]   tl_d_opcode;
    logic [14:0]  tl_d_source;
    logic [127:0] tl_d_data;
    logic         tl_d_denied;
    logic         busy;
    logic         err;
`ifdef VX_TL_PERF_EN
    logic [31:0]  perf_reads;
    logic [31:0]  perf_writes;
    logic [31:0]  perf_stall_cycles;
`endif

    always #5 clock = ~clock;

    vx_tl_source_tracker dut (
        .clock(clock), .reset_n(reset_n),
        .core_req_valid(core_req_valid), .core_req_rw(core_req_rw),
        .core_req_byteen(core_req_byteen), .core_req_addr(core_req_addr),
        .core_req_data(core_req_data), .core_req_tag(core_req_tag),
        .core_req_ready(core_req_ready),
        .core_rsp_valid(core_rsp_valid), .core_rsp_data(core_rsp_data),
        .core_rsp_tag(core_rsp_tag), .core_rsp_ready(core_rsp_ready),
        .tl_a_valid(tl_a_valid), .tl_a_ready(tl_a_ready), .tl_a_opcode(tl_a_opcode),
        .tl_a_param(tl_a_param), .tl_a_size(tl_a_size), .tl_a_source(tl_a_source),
        .tl_a_address(tl_a_address), .tl_a_mask(tl_a_mask), .tl_a_data(tl_a_data),
        .tl_a_corrupt(tl_a_corrupt),
        .tl_d_valid(tl_d_valid), .tl_d_ready(tl_d_ready), .tl_d_opcode(tl_d_opcode),
        .tl_d_source(tl_d_source), .tl_d_data(tl_d_data), .tl_d_denied(tl_d_denied),
`ifdef VX_TL_PERF_EN
        .perf_reads(perf_reads), .perf_writes(perf_writes),
        .perf_stall_cycles(perf_stall_cycles),
`endif
        .busy(busy), .err(err)
    );

    typedef struct {
        logic         rw;
        logic [2:0]   op;
        logic [31:0]  addr;
        logic [15:0]  mask;
        logic [127:0] data;
        logic [14:0]  tag;
    } a_exp_t;

    a_exp_t      a_q[$];
    logic [7:0]  m_busy;
    logic [7:0]  m_rw;
    logic [14:0] m_tag [8];
    logic        m_hold;
    logic [2:0]  m_hold_src;
    logic        m_err;

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [2:0] lowest_free(input logic [7:0] b);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (!b[i]) r = 3'(i);
        end
        return r;
    endfunction

    // Reference model and scoreboard, sampled away from the active edge
    always @(negedge clock) begin
        logic [2:0] exp_src;
        logic       exp_av;
        logic       d_busy;
        logic       d_bad;
        logic       exp_rv;
        logic [2:0] didx;
        a_exp_t     e;
        if (!reset_n) begin
            a_q.delete();
            m_busy = '0;
            m_rw   = '0;
            m_hold = 1'b0;
            m_err  = 1'b0;
        end else begin
            exp_src = m_hold ? m_hold_src : lowest_free(m_busy);
            exp_av  = (a_q.size() != 0) && (m_busy != 8'hFF);
            chk("a_valid", 128'(tl_a_valid), 128'(exp_av));
            chk("req_ready", 128'(core_req_ready), 128'(a_q.size() < 2));
            chk("busy", 128'(busy), 128'((a_q.size() != 0) || (m_busy != 8'h00)));
            chk("err", 128'(err), 128'(m_err));
            if (tl_a_valid && exp_av) begin
                e = a_q[0];
                chk("a_source", 128'(tl_a_source), 128'(exp_src));
                chk("a_opcode", 128'(tl_a_opcode), 128'(e.op));
                chk("a_address", 128'(tl_a_address), 128'(e.addr));
                chk("a_mask", 128'(tl_a_mask), 128'(e.mask));
                chk("a_data", tl_a_data, e.data);
                chk("a_consts", 128'({tl_a_param, tl_a_size, tl_a_corrupt}), 128'({3'd0, 4'd4, 1'b0}));
            end

            didx   = tl_d_source[2:0];
            d_busy = (tl_d_source < 15'd8) && m_busy[didx];
            d_bad  = !d_busy || (tl_d_opcode > 3'd1) || tl_d_denied
                   || (tl_d_opcode == 3'd0 && !m_rw[didx])
                   || (tl_d_opcode == 3'd1 && m_rw[didx]);
            exp_rv = (tl_d_opcode == 3'd1) && !d_bad;
            if (tl_d_valid) begin
                chk("d_ready", 128'(tl_d_ready), 128'((tl_d_opcode == 3'd0) ? 1'b1 : core_rsp_ready));
                chk("rsp_valid", 128'(core_rsp_valid), 128'(exp_rv));
                if (exp_rv) begin
                    chk("rsp_tag", 128'(core_rsp_tag), 128'(m_tag[didx]));
                    chk("rsp_data", core_rsp_data, tl_d_data);
                end
            end

            if (tl_a_valid && tl_a_ready && exp_av) begin
                e = a_q.pop_front();
                m_busy[exp_src] = 1'b1;
                m_rw[exp_src]   = e.rw;
                m_tag[exp_src]  = e.tag;
                m_hold = 1'b0;
            end else if (exp_av && !tl_a_ready) begin
                m_hold     = 1'b1;
                m_hold_src = exp_src;
            end
            if (tl_d_valid && tl_d_ready) begin
                if (d_bad) m_err = 1'b1;
                if (d_busy) m_busy[didx] = 1'b0;
            end

            if (core_req_valid && core_req_ready) begin
                e.rw   = core_req_rw;
                e.op   = core_req_rw ? ((core_req_byteen == 16'hFFFF) ? 3'd0 : 3'd1) : 3'd4;
                e.addr = {core_req_addr, 4'b0000};
                e.mask = core_req_rw ? core_req_byteen : 16'hFFFF;
                e.data = core_req_data;
                e.tag  = core_req_tag;
                a_q.push_back(e);
            end
        end
    end

    // All tasks start and end at posedge + 1
    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
    endtask

    task automatic req(input logic rw, input logic [15:0] be, input logic [27:0] addr, input logic [14:0] tag);
        logic ok;
        ok = 1'b0;
        core_req_valid  = 1'b1;
        core_req_rw     = rw;
        core_req_byteen = be;
        core_req_addr   = addr;
        core_req_tag    = tag;
        core_req_data   = {$urandom, $urandom, $urandom, $urandom};
        for (int k = 0; k < 50; k++) begin
            @(negedge clock);
            if (core_req_ready) begin ok = 1'b1; break; end
        end
        chk("req_timeout", 128'(ok), 128'(1'b1));
        @(posedge clock);
        #1 core_req_valid = 1'b0;
    endtask

    task automatic d_beat(input logic [2:0] op, input logic [14:0] src, input logic den);
        logic ok;
        ok = 1'b0;
        tl_d_valid  = 1'b1;
        tl_d_opcode = op;
        tl_d_source = src;
        tl_d_denied = den;
        tl_d_data   = {$urandom, $urandom, $urandom, $urandom};
        for (int k = 0; k < 50; k++) begin
            @(negedge clock);
            if (tl_d_ready) begin ok = 1'b1; break; end
        end
        chk("d_timeout", 128'(ok), 128'(1'b1));
        @(posedge clock);
        #1 tl_d_valid = 1'b0;
        tl_d_denied = 1'b0;
    endtask

    task automatic drain();
        logic found;
        logic [2:0] s;
        core_rsp_ready = 1'b1;
        tl_a_ready     = 1'b1;
        for (int it = 0; it < 64 && (m_busy != 8'h00 || a_q.size() != 0); it++) begin
            found = 1'b0;
            s     = 3'd0;
            for (int i = 7; i >= 0; i--) begin
                if (m_busy[i]) begin found = 1'b1; s = 3'(i); end
            end
            if (found) d_beat(m_rw[s] ? 3'd0 : 3'd1, 15'(s), 1'b0);
            else begin @(posedge clock); #1; end
        end
        @(negedge clock);
        chk("drain_busy", 128'(busy), 128'(1'b0));
        @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        core_req_valid = 1'b0; core_req_rw = 1'b0; core_req_byteen = '0;
        core_req_addr = '0; core_req_data = '0; core_req_tag = '0;
        core_rsp_ready = 1'b1; tl_a_ready = 1'b1;
        tl_d_valid = 1'b0; tl_d_opcode = 3'd0; tl_d_source = '0;
        tl_d_data = '0; tl_d_denied = 1'b0;
        m_busy = '0; m_rw = '0; m_hold = 1'b0; m_hold_src = '0; m_err = 1'b0;
        @(posedge clock);
        #1 do_reset();

        // Reset state
        @(negedge clock);
        chk("rst_a_valid", 128'(tl_a_valid), 128'(1'b0));
        chk("rst_rsp_valid", 128'(core_rsp_valid), 128'(1'b0));
        chk("rst_busy", 128'(busy), 128'(1'b0));
        chk("rst_req_ready", 128'(core_req_ready), 128'(1'b1));
        chk("rst_err", 128'(err), 128'(1'b0));
        @(posedge clock);
        #1;

        // Single read
        req(1'b0, 16'hFFFF, 28'h8000000, 15'h12);
        @(negedge clock);
        chk("rd_a_valid", 128'(tl_a_valid), 128'(1'b1));
        chk("rd_opcode", 128'(tl_a_opcode), 128'(3'd4));
        chk("rd_source", 128'(tl_a_source), 128'(15'd0));
        chk("rd_address", 128'(tl_a_address), 128'(32'h8000_0000));
        chk("rd_mask", 128'(tl_a_mask), 128'(16'hFFFF));
        @(posedge clock);
        #1 d_beat(3'd1, 15'd0, 1'b0);
        @(negedge clock);
        chk("rd_busy_after", 128'(busy), 128'(1'b0));
        @(posedge clock);
        #1;

        // Full and partial writes; acks sink even with the core stalled
        core_rsp_ready = 1'b0;
        req(1'b1, 16'hFFFF, 28'h0000010, 15'h21);
        @(negedge clock);
        chk("wr_full_op", 128'(tl_a_opcode), 128'(3'd0));
        chk("wr_full_mask", 128'(tl_a_mask), 128'(16'hFFFF));
        @(posedge clock);
        #1 req(1'b1, 16'h00F0, 28'h0000020, 15'h22);
        @(negedge clock);
        chk("wr_part_op", 128'(tl_a_opcode), 128'(3'd1));
        chk("wr_part_mask", 128'(tl_a_mask), 128'(16'h00F0));
        @(posedge clock);
        #1 d_beat(3'd0, 15'd0, 1'b0);
        d_beat(3'd0, 15'd1, 1'b0);
        drain();

        // Source exhaustion
        for (int i = 0; i < 10; i++) req(1'b0, 16'hFFFF, 28'(32'h100 + i), 15'(32'h40 + i));
        repeat (2) @(negedge clock);
        chk("exh_a_valid", 128'(tl_a_valid), 128'(1'b0));
        chk("exh_req_ready", 128'(core_req_ready), 128'(1'b0));
        @(posedge clock);
        #1 d_beat(3'd1, 15'd3, 1'b0);
        @(negedge clock);
        chk("exh_reuse_valid", 128'(tl_a_valid), 128'(1'b1));
        chk("exh_reuse_src", 128'(tl_a_source), 128'(15'd3));
        @(posedge clock);
        #1 drain();

        // A backpressure: fields and source held
        tl_a_ready = 1'b0;
        req(1'b0, 16'hFFFF, 28'h0000123, 15'h33);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk("bp_valid", 128'(tl_a_valid), 128'(1'b1));
            chk("bp_source", 128'(tl_a_source), 128'(15'd0));
            chk("bp_address", 128'(tl_a_address), 128'(32'h0000_1230));
        end
        @(posedge clock);
        #1 tl_a_ready = 1'b1;
        @(posedge clock);
        // D backpressure on AccessAckData
        #1 core_rsp_ready = 1'b0;
        tl_d_valid = 1'b1; tl_d_opcode = 3'd1; tl_d_source = 15'd0;
        tl_d_data = {$urandom, $urandom, $urandom, $urandom};
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("dbp_ready", 128'(tl_d_ready), 128'(1'b0));
            chk("dbp_busy", 128'(busy), 128'(1'b1));
        end
        @(posedge clock);
        #1 core_rsp_ready = 1'b1;
        @(posedge clock);
        #1 tl_d_valid = 1'b0;
        @(negedge clock);
        chk("dbp_busy_after", 128'(busy), 128'(1'b0));
        @(posedge clock);
        #1;

        // Same-cycle A fire on source 1 and D free of source 0
        req(1'b0, 16'hFFFF, 28'h0000200, 15'h50);
        @(posedge clock);
        #1 tl_a_ready = 1'b0;
        req(1'b0, 16'hFFFF, 28'h0000201, 15'h51);
        @(negedge clock);
        chk("sc_held_src", 128'(tl_a_source), 128'(15'd1));
        @(posedge clock);
        #1 tl_a_ready = 1'b1;
        tl_d_valid = 1'b1; tl_d_opcode = 3'd1; tl_d_source = 15'd0;
        tl_d_data = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clock);
        chk("sc_a_src", 128'(tl_a_source), 128'(15'd1));
        chk("sc_d_ready", 128'(tl_d_ready), 128'(1'b1));
        @(posedge clock);
        #1 tl_d_valid = 1'b0;
        req(1'b0, 16'hFFFF, 28'h0000202, 15'h52);
        @(negedge clock);
        chk("sc_next_src", 128'(tl_a_source), 128'(15'd0));
        @(posedge clock);
        #1 drain();

        // Errors: denied response, then stray source
        req(1'b0, 16'hFFFF, 28'h0000300, 15'h60);
        @(posedge clock);
        #1 d_beat(3'd1, 15'd0, 1'b1);
        @(negedge clock);
        chk("denied_err", 128'(err), 128'(1'b1));
        chk("denied_busy", 128'(busy), 128'(1'b0));
        @(posedge clock);
        #1 do_reset();
        d_beat(3'd1, 15'd5, 1'b0);
        @(negedge clock);
        chk("stray_err", 128'(err), 128'(1'b1));
        @(posedge clock);
        #1 do_reset();
        @(negedge clock);
        chk("clr_err", 128'(err), 128'(1'b0));
        chk("clr_busy", 128'(busy), 128'(1'b0));
        chk("clr_a_valid", 128'(tl_a_valid), 128'(1'b0));
        @(posedge clock);

        // Late D after a mid-flight reset
        #1 req(1'b0, 16'hFFFF, 28'h0000400, 15'h70);
        @(posedge clock);
        #1 do_reset();
        d_beat(3'd1, 15'd0, 1'b0);
        @(negedge clock);
        chk("late_d_err", 128'(err), 128'(1'b1));
        @(posedge clock);
        #1 do_reset();
        @(negedge clock);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
